// File: rtl/i281_pkg.sv
// Shared types and default sizing for the i281 multicycle sequencer.
package i281_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int STEP_W_DEF    = 3;
    localparam int MAX_STEPS_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } seq_state_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Decoder-side bundle: request, control and sequencer status.
interface multicycle_sequencer_if
    import i281_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP_W = STEP_W_DEF
);
    logic              run;
    logic              start;
    logic [STEP_W-1:0] step_count;
    logic [DATA_W-1:0] base_op;
    logic              abort;
    logic              busy;
    logic [STEP_W-1:0] step;
    logic [DATA_W-1:0] micro_op;
    logic              last;
    logic              pc_hold;
    logic              done;
    logic              err;

    modport master (
        output run, start, step_count, base_op, abort,
        input  busy, step, micro_op, last, pc_hold, done, err
    );

    modport slave (
        input  run, start, step_count, base_op, abort,
        output busy, step, micro_op, last, pc_hold, done, err
    );
endinterface

// File: rtl/multicycle_sequencer_step_counter.sv
// Micro-step index counter; clear has priority over increment.
module step_counter #(
    parameter int STEP_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [STEP_W-1:0] step_o
);
    logic [STEP_W-1:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (clr_i)
            step_d = '0;
        else if (inc_i)
            step_d = step_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            step_q <= '0;
        else if (en_i)
            step_q <= step_d;
    end

    assign step_o = step_q;
endmodule

// File: rtl/multicycle_sequencer.sv
// Expands one multicycle instruction into a run of indexed micro-ops,
// stalling the PC until the final step.
module multicycle_sequencer
    import i281_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int STEP_W    = STEP_W_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF
) (
    input logic clk_i,
    input logic rst_ni,
    multicycle_sequencer_if.slave bus
);
    seq_state_e        state_q;
    logic [DATA_W-1:0] base_q;
    logic [STEP_W-1:0] cnt_q;
    logic              done_q;
    logic              err_q;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] idx;
    logic              busy;
    logic              last;
    logic              cnt_ok;

    assign busy   = (state_q == EXEC);
    assign last   = busy && (step == STEP_W'(cnt_q - 1'b1));
    assign idx    = base_q[STEP_W-1:0] + step;
    assign cnt_ok = (bus.step_count != '0) &&
                    (bus.step_count <= STEP_W'(MAX_STEPS));

    // Index stays cleared outside EXEC so every sequence starts at step 0.
    step_counter #(.STEP_W(STEP_W)) u_step (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (bus.run),
        .clr_i  (!busy || bus.abort || last),
        .inc_i  (busy),
        .step_o (step)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.run) begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start && cnt_ok) begin
                        state_q <= EXEC;
                        base_q  <= bus.base_op;
                        cnt_q   <= bus.step_count;
                        err_q   <= 1'b0;
                    end else if (bus.start) begin
                        err_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.step     = step;
    assign bus.last     = last;
    assign bus.pc_hold  = busy && !last;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.micro_op = busy ? {base_q[DATA_W-1:STEP_W], idx} : '0;
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, micro-op word width.
REQ-002 Parameter STEP_W, default 3, width of step index and step count.
REQ-003 Parameter MAX_STEPS, default 4, largest legal step count; SHALL satisfy 1 <= MAX_STEPS <= 2**STEP_W - 1.
REQ-004 clock  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  global advance enable; low freezes all state.
REQ-007 start  input  1  multicycle instruction present, from the multicycle decoder.
REQ-008 step_count  input  STEP_W  number of micro-steps requested.
REQ-009 base_op  input  DATA_W  micro-op template; low STEP_W bits hold the base index.
REQ-010 abort  input  1  cancel the sequence in progress.
REQ-011 busy  output  1  sequence in progress.
REQ-012 step  output  STEP_W  current micro-step index.
REQ-013 micro_op  output  DATA_W  micro-op for the opcode decoder; valid while busy.
REQ-014 last  output  1  current step is the final one.
REQ-015 pc_hold  output  1  stall request to the program counter.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  sticky illegal-count flag.

Function
REQ-018 States SHALL be IDLE and EXEC; busy SHALL be 1 exactly in EXEC.
REQ-019 No state, counter, latch or registered output SHALL change on a rising edge with run=0.
REQ-020 IDLE, run=1, start=1, 1 <= step_count <= MAX_STEPS: next state EXEC, step=0, base_op and step_count latched, err cleared.
REQ-021 IDLE, run=1, start=1, step_count=0 or > MAX_STEPS: remain IDLE, err set to 1.
REQ-022 In EXEC, start and the live base_op/step_count inputs SHALL be ignored; only the latched copies are used.
REQ-023 micro_op SHALL equal latched base_op[DATA_W-1:STEP_W] concatenated with (latched base_op[STEP_W-1:0] + step) mod 2**STEP_W; it SHALL be 0 in IDLE.
REQ-024 last SHALL be combinational: busy AND step == latched count - 1.
REQ-025 pc_hold SHALL be combinational: busy AND NOT last, so the PC advances on the final step.
REQ-026 EXEC, run=1, abort=0, last=0: step increments by 1.
REQ-027 EXEC, run=1, abort=0, last=1: next state IDLE, step=0, done=1 for the following cycle only.
REQ-028 EXEC, run=1, abort=1: next state IDLE, step=0, done stays 0; abort wins over last.
REQ-029 abort in IDLE SHALL have no effect and SHALL NOT block a simultaneous start.
REQ-030 Count 1 SHALL give exactly one EXEC cycle with last=1 and pc_hold=0.
REQ-031 Latency from the start edge to the done pulse SHALL be count+1 run-enabled cycles.

Reset
REQ-032 reset=0 SHALL force IDLE, step=0, latches=0, done=0 and err=0 immediately, without waiting for a clock edge; this also applies in the middle of a sequence.
REQ-033 With reset held low, busy, micro_op, last, pc_hold and done SHALL all read 0.
REQ-034 After reset is released, the first state change SHALL occur on the first rising edge with run=1.

Structure
REQ-035 The state enumeration and the default values of DATA_W, STEP_W and MAX_STEPS SHALL reside in the shared package i281_pkg.
REQ-036 The step counter (clear, increment, run enable) SHALL be one sub-module, step_counter, parameterised by STEP_W.
REQ-037 All outputs except last, pc_hold and micro_op SHALL be driven directly from flops.

Verification
REQ-038 Stimulus: start, count=3, base_op=0x15, run=1. Required: busy for 3 cycles; micro_op=0x15, 0x16, 0x17; pc_hold=1,1,0; done pulse in the 4th cycle.
REQ-039 Stimulus: STEP_W=3, base_op=0x0E, count=4. Required: micro_op=0x0E, 0x0F, 0x08, 0x09 (index wraps within the low bits).
REQ-040 Stimulus: count=0, then count=5, with MAX_STEPS=4. Required: err=1, busy stays 0; a following valid start clears err.
REQ-041 Stimulus: run=0 for 2 cycles during step 1 of a count=4 sequence. Required: step holds at 1; done is delayed by 2 cycles.
REQ-042 Stimulus: abort asserted together with last on a count=2 sequence. Required: IDLE next cycle, done never asserted.
REQ-043 Stimulus: reset driven low between clock edges during step 2. Required: busy=0 and step=0 immediately, with no done pulse.
